// File: rtl/sampling.sv
// Purpose : UART receiver oversampling strobe (8x or 16x the selected baud rate) from the system clock.
// Latency : BaudOut is registered; first strobe N clocks after reset release or a config change edge.
// Backpressure: none; free-running strobe. `define SAMPLING_PHASE_EN adds SampleIdx/MidBit phase outputs.
module sampling #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CNT_W    = 12
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       OverSel,
    input  logic [1:0] BaudRate,
`ifdef SAMPLING_PHASE_EN
    output logic [3:0] SampleIdx,
    output logic       MidBit,
`endif
    output logic       BaudOut
);

    // Rounded divisors, evaluated at elaboration time only.
    localparam int DIV_2400_8   = (CLK_FREQ + 2400 * 8 / 2)   / (2400 * 8);
    localparam int DIV_4800_8   = (CLK_FREQ + 4800 * 8 / 2)   / (4800 * 8);
    localparam int DIV_9600_8   = (CLK_FREQ + 9600 * 8 / 2)   / (9600 * 8);
    localparam int DIV_19200_8  = (CLK_FREQ + 19200 * 8 / 2)  / (19200 * 8);
    localparam int DIV_2400_16  = (CLK_FREQ + 2400 * 16 / 2)  / (2400 * 16);
    localparam int DIV_4800_16  = (CLK_FREQ + 4800 * 16 / 2)  / (4800 * 16);
    localparam int DIV_9600_16  = (CLK_FREQ + 9600 * 16 / 2)  / (9600 * 16);
    localparam int DIV_19200_16 = (CLK_FREQ + 19200 * 16 / 2) / (19200 * 16);

    logic [2:0]       cfgIn;
    logic [2:0]       cfgQ;
    logic             cfgLoaded;
    logic             cfgChange;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lastCnt;

    assign cfgIn = {OverSel, BaudRate};

    // The first edge after reset only captures the configuration; it is not a change.
    assign cfgChange = cfgLoaded && (cfgIn != cfgQ);

    // Terminal count for the live configuration (a change restarts the count anyway).
    always_comb begin
        lastCnt = '0;
        case (cfgIn)
            3'b000:  lastCnt = CNT_W'(DIV_2400_8   - 1);
            3'b001:  lastCnt = CNT_W'(DIV_4800_8   - 1);
            3'b010:  lastCnt = CNT_W'(DIV_9600_8   - 1);
            3'b011:  lastCnt = CNT_W'(DIV_19200_8  - 1);
            3'b100:  lastCnt = CNT_W'(DIV_2400_16  - 1);
            3'b101:  lastCnt = CNT_W'(DIV_4800_16  - 1);
            3'b110:  lastCnt = CNT_W'(DIV_9600_16  - 1);
            default: lastCnt = CNT_W'(DIV_19200_16 - 1);
        endcase
    end

    // Divisor counter and registered one-cycle strobe; a config change restarts the period silently.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt       <= '0;
            BaudOut   <= 1'b0;
            cfgQ      <= 3'b000;
            cfgLoaded <= 1'b0;
        end else begin
            cfgQ      <= cfgIn;
            cfgLoaded <= 1'b1;
            if (cfgChange) begin
                cnt     <= '0;
                BaudOut <= 1'b0;
            end else if (cnt >= lastCnt) begin
                cnt     <= '0;
                BaudOut <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                BaudOut <= 1'b0;
            end
        end
    end

`ifdef SAMPLING_PHASE_EN
    logic [3:0] lastIdx;
    logic [3:0] midIdx;

    assign lastIdx = cfgQ[2] ? 4'd15 : 4'd7;
    assign midIdx  = cfgQ[2] ? 4'd7  : 4'd3;

    // Strobe index within one bit time; advances after each strobe, restarts on a config change.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            SampleIdx <= 4'd0;
        end else if (cfgChange) begin
            SampleIdx <= 4'd0;
        end else if (BaudOut) begin
            SampleIdx <= (SampleIdx == lastIdx) ? 4'd0 : SampleIdx + 4'd1;
        end
    end

    // Bit-centre strobe; SampleIdx still shows the index of the strobe currently high.
    assign MidBit = BaudOut && (SampleIdx == midIdx);
`endif

endmodule

// File: tb/tb_sampling.sv
// Purpose : directed scoreboard bench for the oversampling strobe generator.
// Latency : expected strobe cycles are queued by the stimulus and matched by a negedge monitor.
// Backpressure: none; every strobe must match the head of the queue at the exact cycle.
module tb_sampling;

    logic       Clock = 1'b0;
    logic       ResetN;
    logic       OverSel;
    logic [1:0] BaudRate;
    logic       BaudOut;
`ifdef SAMPLING_PHASE_EN
    logic [3:0] SampleIdx;
    logic       MidBit;
`endif

    sampling dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .OverSel  (OverSel),
        .BaudRate (BaudRate),
`ifdef SAMPLING_PHASE_EN
        .SampleIdx(SampleIdx),
        .MidBit   (MidBit),
`endif
        .BaudOut  (BaudOut)
    );

    // 50 MHz clock
    always #10 Clock = ~Clock;

    // Rising edges seen so far; read on the falling edge.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int t;
        int idx;
        bit mid;
    } exp_t;

    exp_t q[$];
    int   nAssert  = 0;
    int   nFail    = 0;
    int   pulseCnt = 0;

    // Hand-computed divisors indexed by {OverSel,BaudRate}.
    int divTab[8] = '{2604, 1302, 651, 326, 1302, 651, 326, 163};

    task automatic chk(input string nm, input int act, input int req);
        nAssert++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Apply cfg at a falling edge, queue every strobe due within the next len edges, and run them.
    // off=1: the next edge is a change edge; off=0: counting starts from a fresh reset release.
    task automatic segment(input logic [2:0] cfg, input int len, input int off);
        int   c0;
        int   n;
        int   ratio;
        exp_t e;
        {OverSel, BaudRate} = cfg;
        c0    = cyc;
        n     = divTab[cfg];
        ratio = cfg[2] ? 16 : 8;
        for (int k = 1; off + k * n <= len; k++) begin
            e.t   = c0 + off + k * n;
            e.idx = (k - 1) % ratio;
            e.mid = (e.idx == ratio / 2 - 1);
            q.push_back(e);
        end
        repeat (len) @(negedge Clock);
    endtask

    // Monitor: every strobe must be the next queued one, at its exact cycle.
    always @(negedge Clock) begin
        exp_t e;
        if (BaudOut === 1'b1) begin
            pulseCnt++;
            if (q.size() == 0) begin
                chk("unexpected BaudOut pulse", 1, 0);
            end else begin
                e = q.pop_front();
                chk("BaudOut pulse cycle", cyc, e.t);
`ifdef SAMPLING_PHASE_EN
                chk("SampleIdx", int'(SampleIdx), e.idx);
                chk("MidBit", int'(MidBit), int'(e.mid));
`endif
            end
        end
    end

    logic [2:0] sweep[6] = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001};

    initial begin
        int start;
        ResetN              = 1'b0;
        {OverSel, BaudRate} = 3'b111;
        #5;
        chk("BaudOut in reset", int'(BaudOut), 0);
`ifdef SAMPLING_PHASE_EN
        chk("SampleIdx in reset", int'(SampleIdx), 0);
        chk("MidBit in reset", int'(MidBit), 0);
`endif
        @(negedge Clock);
        ResetN = 1'b1;

        // 250 us at 16x/19200: strobe every 163 clocks, 76 of them
        start = pulseCnt;
        segment(3'b111, 12500, 0);
        #1;
        chk("pulse count cfg 111 over 250us", pulseCnt - start, 76);

        // remaining configs, three periods each (plus a partial period)
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            start = pulseCnt;
            segment(sweep[i], 3 * divTab[sweep[i]] + 50, 1);
            #1;
            chk("pulse count in sweep", pulseCnt - start, 3);
        end

        // slowest setting over 250 us
        @(negedge Clock);
        start = pulseCnt;
        segment(3'b000, 12500, 1);
        #1;
        chk("pulse count cfg 000 over 250us", pulseCnt - start, 4);

        // 111 -> 000 mid-count: silence for 2604 clocks after the change edge
        @(negedge Clock);
        segment(3'b111, 500, 1);
        start = pulseCnt;
        segment(3'b000, 3000, 1);
        #1;
        chk("pulses after 111->000 change", pulseCnt - start, 1);

        // reset pulse while a strobe is high (pulse lands on edge 979 of this segment)
        @(negedge Clock);
        segment(3'b111, 979, 1);
        #2;
        chk("BaudOut high before mid reset", int'(BaudOut), 1);
        ResetN = 1'b0;
        #1;
        chk("BaudOut cleared at once by reset", int'(BaudOut), 0);
`ifdef SAMPLING_PHASE_EN
        chk("SampleIdx cleared by reset", int'(SampleIdx), 0);
`endif
        @(negedge Clock);
        ResetN = 1'b1;
        start  = pulseCnt;
        segment(3'b111, 2000, 0);
        #1;
        chk("pulses after mid-period reset", pulseCnt - start, 12);

        chk("scoreboard entries left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
